// File: rtl/dmem_pkg.sv
// dmem_pkg: shared transfer-size and state types plus lane-mask helpers for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} xfer_size_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    function automatic logic [7:0] size_to_bytemask(input xfer_size_t sz);
        return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0f : 8'hff;
    endfunction

    function automatic logic [63:0] bytemask_to_bitmask(input logic [7:0] bm);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i+:8] = {8{bm[i]}};
        return m;
    endfunction

    function automatic logic is_misaligned(input xfer_size_t sz, input logic [2:0] lane);
        return (sz == SZ_H && lane[0]) || (sz == SZ_W && |lane[1:0]) || (sz == SZ_D && |lane);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 64 synchronous RAM with byte-write enables and registered read
module dmem_array #(
    parameter int DEPTH_WORDS = 128,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [7:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    // byte-lane write and registered read share one address; contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (we[i]) mem[addr][8*i+:8] <= wdata[8*i+:8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder behind the MEM-stage data port
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state, state_nx;
    logic [3:0]    cnt;
    logic          wr_q;
    xfer_size_t    size_q;
    logic [63:0]   addr_q, wdata_q;
    logic          accept, err;
    logic [5:0]    sh;
    logic [7:0]    be;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_wdata, ram_rdata, load_data;

    // datapath: the RAM reads the incoming address on acceptance so data is ready even when LATENCY==1
    always_comb begin
        accept = req_valid && req_ready;
        sh = {addr_q[2:0], 3'b000};
        err = is_misaligned(size_q, addr_q[2:0]) || addr_q >= 64'(DEPTH_WORDS * 8);
        be = (state == RESP && wr_q && !err) ? size_to_bytemask(size_q) << addr_q[2:0] : 8'h00;
        ram_addr = accept ? req_addr[3+:AW] : addr_q[3+:AW];
        ram_wdata = wdata_q << sh;
        load_data = (ram_rdata >> sh) & bytemask_to_bitmask(size_to_bytemask(size_q));
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    // next state: single-cycle latency skips WAIT entirely
    always_comb begin
        state_nx = state == IDLE ? (accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                   state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    end

    // handshake outputs: only an idle responder takes a request
    always_comb begin
        req_ready = state == IDLE;
        busy = !req_ready;
    end

    // request latch and wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
            wr_q <= 1'b0;
            size_q <= SZ_B;
            addr_q <= 64'd0;
            wdata_q <= 64'd0;
        end else if (accept) begin
            cnt <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
            wr_q <= req_write;
            size_q <= xfer_size_t'(req_size);
            addr_q <= req_addr;
            wdata_q <= req_wdata;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // completion: the RESP->IDLE edge commits the result, which then holds until the next completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err <= 1'b0;
        end else begin
            resp_valid <= state == RESP;
            if (state == RESP) begin
                resp_err <= err;
                resp_rdata <= (err || wr_q) ? 64'd0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders (LATENCY 3 and 1) against a byte-array model
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int L0 = 3;
    localparam int L1 = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_write [2];
    logic [1:0]  req_size [2];
    logic [63:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic        req_ready [2];
    logic        resp_valid [2];
    logic        resp_err [2];
    logic        busy [2];
    logic [63:0] resp_rdata [2];

    logic [7:0] mem_m [2][DEPTH*8];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .busy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int lat(input int d);
        return d == 0 ? L0 : L1;
    endfunction

    // reference: a transfer of 2**sz bytes, legal only when aligned and fully inside the array
    function automatic void model(input int d, input bit wr, input int sz, input logic [63:0] addr,
                                  input logic [63:0] wd, output bit err, output logic [63:0] rd);
        int n = 1 << sz;
        err = addr >= 64'(DEPTH * 8) || (int'(addr[2:0]) % n) != 0;
        rd = 64'd0;
        if (!err)
            for (int i = 0; i < n; i++)
                if (wr) mem_m[d][int'(addr) + i] = wd[8*i+:8];
                else rd[8*i+:8] = mem_m[d][int'(addr) + i];
    endfunction

    task automatic issue(input int d, input bit wr, input int sz, input logic [63:0] addr, input logic [63:0] wd);
        int t = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_size[d] = 2'(sz);
        req_addr[d] = addr;
        req_wdata[d] = wd;
        while (!req_ready[d] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[d]) check($sformatf("d%0d ready_timeout", d), 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic do_req(input int d, input bit wr, input int sz, input logic [63:0] addr, input logic [63:0] wd);
        bit e;
        logic [63:0] r;
        int l = lat(d);
        model(d, wr, sz, addr, wd, e, r);
        issue(d, wr, sz, addr, wd);
        for (int k = 1; k <= l + 2; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("d%0d resp_valid k%0d @%h", d, k, addr), 64'(resp_valid[d]), 64'(k == l + 1));
            check($sformatf("d%0d busy k%0d @%h", d, k, addr), 64'(busy[d]), 64'(k <= l));
            if (k >= l + 1) begin
                check($sformatf("d%0d rdata k%0d @%h", d, k, addr), resp_rdata[d], r);
                check($sformatf("d%0d err k%0d @%h", d, k, addr), 64'(resp_err[d]), 64'(e));
            end
        end
    endtask

    task automatic streaming(input int d);
        logic [63:0] exp_q [$];
        int acc [3];
        int nacc = 0;
        int nresp = 0;
        int last = -100;
        int l = lat(d);
        bit e;
        logic [63:0] r;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b0;
        for (int cyc = 0; cyc < 60 && nresp < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            check($sformatf("d%0d stream valid c%0d", d, cyc), 64'(resp_valid[d]), 64'(cyc - last == l + 1));
            check($sformatf("d%0d stream busy c%0d", d, cyc), 64'(busy[d]), 64'(cyc - last >= 1 && cyc - last <= l));
            if (resp_valid[d]) begin
                if (exp_q.size() > 0) check($sformatf("d%0d stream rdata c%0d", d, cyc), resp_rdata[d], exp_q.pop_front());
                else check($sformatf("d%0d stream extra resp c%0d", d, cyc), 64'd1, 64'd0);
                nresp++;
            end
            if (req_ready[d]) begin
                if (nacc < 3) begin
                    int sz = $urandom_range(0, 3);
                    logic [63:0] a = 64'($urandom_range(0, DEPTH * 8 - 1)) & ~64'((1 << sz) - 1);
                    req_size[d] = 2'(sz);
                    req_addr[d] = a;
                    model(d, 1'b0, sz, a, 64'd0, e, r);
                    exp_q.push_back(r);
                    acc[nacc] = cyc;
                    last = cyc;
                    nacc++;
                end else begin
                    req_valid[d] = 1'b0;
                end
            end
        end
        req_valid[d] = 1'b0;
        check($sformatf("d%0d stream accepts", d), 64'(nacc), 64'd3);
        check($sformatf("d%0d stream responses", d), 64'(nresp), 64'd3);
        check($sformatf("d%0d stream spacing01", d), 64'(acc[1] - acc[0]), 64'(l + 1));
        check($sformatf("d%0d stream spacing12", d), 64'(acc[2] - acc[1]), 64'(l + 1));
    endtask

    task automatic reset_mid_store(input int d);
        bit e;
        logic [63:0] r;
        do_req(d, 1'b0, 3, 64'h20, 64'd0);
        model(d, 1'b0, 3, 64'h20, 64'd0, e, r);
        issue(d, 1'b1, 3, 64'h20, ~r);
        check($sformatf("d%0d busy before reset", d), 64'(busy[d]), 64'd1);
        reset = 1'b0;
        #1;
        check($sformatf("d%0d async resp_valid", d), 64'(resp_valid[d]), 64'd0);
        check($sformatf("d%0d async busy", d), 64'(busy[d]), 64'd0);
        check($sformatf("d%0d async rdata", d), resp_rdata[d], 64'd0);
        check($sformatf("d%0d async err", d), 64'(resp_err[d]), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check($sformatf("d%0d ready after reset", d), 64'(req_ready[d]), 64'd1);
        do_req(d, 1'b0, 3, 64'h20, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_size[d] = 2'd0;
            req_addr[d] = 64'd0;
            req_wdata[d] = 64'd0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset req_ready", d), 64'(req_ready[d]), 64'd1);
            check($sformatf("d%0d reset resp_valid", d), 64'(resp_valid[d]), 64'd0);
            check($sformatf("d%0d reset busy", d), 64'(busy[d]), 64'd0);
            check($sformatf("d%0d reset rdata", d), resp_rdata[d], 64'd0);
            check($sformatf("d%0d reset err", d), 64'(resp_err[d]), 64'd0);
        end
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) do_req(d, 1'b1, 3, 64'(w * 8), {$urandom, $urandom});
            do_req(d, 1'b1, 3, 64'h10, 64'h0123456789ABCDEF);
            do_req(d, 1'b0, 3, 64'h10, 64'd0);
            check($sformatf("d%0d dword load const", d), resp_rdata[d], 64'h0123456789ABCDEF);
            do_req(d, 1'b1, 0, 64'h13, 64'hAA);
            do_req(d, 1'b0, 3, 64'h10, 64'd0);
            check($sformatf("d%0d lane3 merge const", d), resp_rdata[d], 64'h01234567AAABCDEF);
            do_req(d, 1'b0, 0, 64'h13, 64'd0);
            check($sformatf("d%0d byte load const", d), resp_rdata[d], 64'h00000000000000AA);
            do_req(d, 1'b0, 2, 64'h12, 64'd0);
            check($sformatf("d%0d misaligned err const", d), 64'(resp_err[d]), 64'd1);
            do_req(d, 1'b1, 3, 64'h400, 64'hDEADBEEFDEADBEEF);
            check($sformatf("d%0d range err const", d), 64'(resp_err[d]), 64'd1);
            do_req(d, 1'b0, 3, 64'h3F8, 64'd0);
            do_req(d, 1'b1, 0, 64'h3FF, 64'h5A);
            do_req(d, 1'b0, 0, 64'h3FF, 64'd0);
            do_req(d, 1'b0, 1, 64'h1_0000_0000, 64'd0);
            for (int n = 0; n < 60; n++) begin
                int sz = $urandom_range(0, 3);
                int kind = $urandom_range(0, 9);
                logic [63:0] a;
                if (kind == 0) a = {$urandom, $urandom};
                else if (kind == 1) a = 64'(DEPTH * 8) + 64'($urandom_range(0, 255));
                else if (kind == 2) a = 64'($urandom_range(0, DEPTH * 8 - 1));
                else a = 64'($urandom_range(0, DEPTH * 8 - 1)) & ~64'((1 << sz) - 1);
                do_req(d, 1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom});
            end
            streaming(d);
            reset_mid_store(d);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
